// File: rtl/sram_arb_pkg.sv
// Shared types for the two-requester SRAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 32;

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter remembering the last granted requester.
// Latency: combinational grant; the pointer updates on the clock edge of a grant.
// Backpressure: en=0 suppresses all grants and freezes the pointer.
// Ports: clk, rst_n (async active-low), req[1:0], en in; gnt[1:0] out (one-hot or zero).
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  req_id_t last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      // On contention the requester that did not win last time goes first.
      if (req == 2'b11) gnt = (last_q == 1'b0) ? 2'b10 : 2'b01;
      else              gnt = req;
      if (gnt[0])      last_d = 1'b0;
      else if (gnt[1]) last_d = 1'b1;
    end
  end

  // Reset value 1 makes REQ0 the first winner on contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin share of one SRAM macro port between REQ0/REQ1, registered macro pins, read data returned to issuer.
// Latency: read data 2 edges after accept (3 edges when SRAM_ARB_OUTREG_EN is defined); writes give no response.
// Backpressure: REQn_READY is a combinational grant; responses cannot be stalled and must be sunk.
// Ports: UserCLK, RST_N, CONFIGURED; REQn_VALID/WE/ADDR/WDATA/BM in, REQn_READY out;
//        RSPn_VALID/RDATA out; SRAM_ADDR/DIN/BM/WEN/REN/MEN out, SRAM_DOUT in; BUSY out.
// Option: SRAM_ARB_OUTREG_EN registers RSPn_VALID/RSPn_RDATA (one extra edge of read latency).
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  UserCLK,
  input  logic                  RST_N,
  input  logic                  CONFIGURED,
  input  logic                  REQ0_VALID,
  input  logic                  REQ0_WE,
  input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
  input  logic [DATA_WIDTH-1:0] REQ0_BM,
  output logic                  REQ0_READY,
  input  logic                  REQ1_VALID,
  input  logic                  REQ1_WE,
  input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
  input  logic [DATA_WIDTH-1:0] REQ1_BM,
  output logic                  REQ1_READY,
  output logic                  RSP0_VALID,
  output logic [DATA_WIDTH-1:0] RSP0_RDATA,
  output logic                  RSP1_VALID,
  output logic [DATA_WIDTH-1:0] RSP1_RDATA,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [DATA_WIDTH-1:0] SRAM_DIN,
  output logic [DATA_WIDTH-1:0] SRAM_BM,
  output logic                  SRAM_WEN,
  output logic                  SRAM_REN,
  output logic                  SRAM_MEN,
  input  logic [DATA_WIDTH-1:0] SRAM_DOUT,
  output logic                  BUSY
);

  state_t                state_q, state_d;
  logic [1:0]            gnt;
  logic                  arb_en, acc, busy;
  logic                  men_q, men_d, wen_q, wen_d, ren_q, ren_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d, bm_q, bm_d;
  req_id_t               cmd_id_q, cmd_id_d, rsp_id_q, rsp_id_d;
  logic                  rsp_vld_q, rsp_vld_d;

  // Grants only in RUN and only while still configured, so nothing new
  // slips in during the cycle CONFIGURED falls.
  assign arb_en = (state_q == RUN) && CONFIGURED;

  rr_arb2 u_rr_arb2 (
    .clk   (UserCLK),
    .rst_n (RST_N),
    .req   ({REQ1_VALID, REQ0_VALID}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign REQ0_READY = gnt[0];
  assign REQ1_READY = gnt[1];
  assign acc        = gnt[0] | gnt[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNCONF:  if (CONFIGURED) state_d = RUN;
      RUN:     if (!CONFIGURED) state_d = DRAIN;
      DRAIN:   if (!busy) state_d = UNCONF;
      default: state_d = UNCONF;
    endcase
  end

  // Command stage: the winner is registered straight onto the macro pins.
  // Address/data/mask hold their last value on idle cycles.
  always_comb begin
    men_d    = acc;
    wen_d    = 1'b0;
    ren_d    = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    bm_d     = bm_q;
    cmd_id_d = cmd_id_q;
    if (gnt[1]) begin
      wen_d = REQ1_WE;  ren_d = ~REQ1_WE;
      addr_d = REQ1_ADDR; din_d = REQ1_WDATA; bm_d = REQ1_BM; cmd_id_d = 1'b1;
    end else if (gnt[0]) begin
      wen_d = REQ0_WE;  ren_d = ~REQ0_WE;
      addr_d = REQ0_ADDR; din_d = REQ0_WDATA; bm_d = REQ0_BM; cmd_id_d = 1'b0;
    end
    // Response stage tracks a read while the macro produces its data.
    rsp_vld_d = ren_q;
    rsp_id_d  = ren_q ? cmd_id_q : rsp_id_q;
  end

  always_ff @(posedge UserCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= UNCONF;
      men_q     <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      bm_q      <= '0;
      cmd_id_q  <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      men_q     <= men_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      bm_q      <= bm_d;
      cmd_id_q  <= cmd_id_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  assign SRAM_MEN  = men_q;
  assign SRAM_WEN  = wen_q;
  assign SRAM_REN  = ren_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_DIN  = din_q;
  assign SRAM_BM   = bm_q;

`ifdef SRAM_ARB_OUTREG_EN
  logic [1:0]            out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;

  always_comb begin
    out_vld_d[0] = rsp_vld_q & (rsp_id_q == 1'b0);
    out_vld_d[1] = rsp_vld_q & (rsp_id_q == 1'b1);
    out_dat_d    = rsp_vld_q ? SRAM_DOUT : out_dat_q;
  end

  always_ff @(posedge UserCLK or negedge RST_N) begin
    if (!RST_N) begin
      out_vld_q <= 2'b00;
      out_dat_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  assign RSP0_VALID = out_vld_q[0];
  assign RSP1_VALID = out_vld_q[1];
  assign RSP0_RDATA = out_vld_q[0] ? out_dat_q : '0;
  assign RSP1_RDATA = out_vld_q[1] ? out_dat_q : '0;
  assign busy       = men_q | rsp_vld_q | (|out_vld_q);
`else
  // Data is forced to zero outside a pulse so an idle or reset port never
  // shows stale macro output.
  assign RSP0_VALID = rsp_vld_q & (rsp_id_q == 1'b0);
  assign RSP1_VALID = rsp_vld_q & (rsp_id_q == 1'b1);
  assign RSP0_RDATA = RSP0_VALID ? SRAM_DOUT : '0;
  assign RSP1_RDATA = RSP1_VALID ? SRAM_DOUT : '0;
  assign busy       = men_q | rsp_vld_q;
`endif

  assign BUSY = busy;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM macro.
// Latency: expects read data 2 edges after accept (3 with SRAM_ARB_OUTREG_EN).
// Backpressure: requesters hold commands until their READY handshake.
module tb_sram_port_arbiter;

`ifdef SRAM_ARB_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        UserCLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CONFIGURED = 1'b0;
  logic        REQ0_VALID = 1'b0, REQ0_WE = 1'b0, REQ1_VALID = 1'b0, REQ1_WE = 1'b0;
  logic [9:0]  REQ0_ADDR = '0, REQ1_ADDR = '0;
  logic [31:0] REQ0_WDATA = '0, REQ0_BM = '0, REQ1_WDATA = '0, REQ1_BM = '0;
  logic        REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID;
  logic [31:0] RSP0_RDATA, RSP1_RDATA;
  logic [9:0]  SRAM_ADDR;
  logic [31:0] SRAM_DIN, SRAM_BM, SRAM_DOUT;
  logic        SRAM_WEN, SRAM_REN, SRAM_MEN, BUSY;

  sram_port_arbiter dut (
    .UserCLK(UserCLK), .RST_N(RST_N), .CONFIGURED(CONFIGURED),
    .REQ0_VALID(REQ0_VALID), .REQ0_WE(REQ0_WE), .REQ0_ADDR(REQ0_ADDR),
    .REQ0_WDATA(REQ0_WDATA), .REQ0_BM(REQ0_BM), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_WE(REQ1_WE), .REQ1_ADDR(REQ1_ADDR),
    .REQ1_WDATA(REQ1_WDATA), .REQ1_BM(REQ1_BM), .REQ1_READY(REQ1_READY),
    .RSP0_VALID(RSP0_VALID), .RSP0_RDATA(RSP0_RDATA),
    .RSP1_VALID(RSP1_VALID), .RSP1_RDATA(RSP1_RDATA),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DIN(SRAM_DIN), .SRAM_BM(SRAM_BM),
    .SRAM_WEN(SRAM_WEN), .SRAM_REN(SRAM_REN), .SRAM_MEN(SRAM_MEN),
    .SRAM_DOUT(SRAM_DOUT), .BUSY(BUSY)
  );

  always #5 UserCLK = ~UserCLK;

  // Behavioural 1024x32 macro: synchronous read, bit-masked write.
  logic [31:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    SRAM_DOUT = '0;
  end
  always @(posedge UserCLK) begin
    if (SRAM_MEN && SRAM_WEN) mem[SRAM_ADDR] <= (mem[SRAM_ADDR] & ~SRAM_BM) | (SRAM_DIN & SRAM_BM);
    if (SRAM_MEN && SRAM_REN) SRAM_DOUT <= mem[SRAM_ADDR];
  end

  int n_pass = 0, n_chk = 0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] din;
    logic [31:0] bm;
  } cmd_t;

  cmd_t        exp_cmd [int];
  int          exp_rsp_id [int];
  logic [31:0] exp_rsp_dat [int];
  bit          busy_mark [int];
  logic [31:0] ref_mem [1024];
  int          mode;     // 0 unconfigured, 1 running, 2 draining
  int          last_g;   // last granted requester
  int          cyc = 0;

  // Observations used by the directed checks.
  bit          acc_seen [2];
  int          acc_cyc0;
  int          ready_cnt = 0, men_cnt = 0, rsp0_cnt = 0, rsp1_cnt = 0;
  int          last_rsp0_cyc;
  logic [31:0] last_rsp0_dat;
  int          gnt_log [$];

  initial begin
    bit   e_men, e_busy, e_r0, e_r1, eg0, eg1;
    int   gid;
    cmd_t c;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    mode = 0;
    last_g = 1;
    forever begin
      @(negedge UserCLK);
      if (!RST_N) begin
        exp_cmd.delete(); exp_rsp_id.delete(); exp_rsp_dat.delete(); busy_mark.delete();
        mode = 0;
        last_g = 1;
        chk("rst_ready0", REQ0_READY, 0);
        chk("rst_ready1", REQ1_READY, 0);
        chk("rst_men", {SRAM_MEN, SRAM_WEN, SRAM_REN}, 0);
        chk("rst_rsp_vld", {RSP0_VALID, RSP1_VALID}, 0);
        chk("rst_rdata", RSP0_RDATA | RSP1_RDATA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_addr", SRAM_ADDR, 0);
      end else begin
        e_men  = exp_cmd.exists(cyc);
        e_busy = busy_mark.exists(cyc);
        e_r0   = exp_rsp_id.exists(cyc) && exp_rsp_id[cyc] == 0;
        e_r1   = exp_rsp_id.exists(cyc) && exp_rsp_id[cyc] == 1;
        eg0 = 0; eg1 = 0;
        if (mode == 1 && CONFIGURED) begin
          if (REQ0_VALID && REQ1_VALID) begin
            if (last_g == 0) eg1 = 1; else eg0 = 1;
          end else begin
            eg0 = REQ0_VALID;
            eg1 = REQ1_VALID;
          end
        end
        chk("ready0", REQ0_READY, eg0);
        chk("ready1", REQ1_READY, eg1);
        chk("men", SRAM_MEN, e_men);
        chk("wen", SRAM_WEN, e_men && exp_cmd[cyc].we);
        chk("ren", SRAM_REN, e_men && !exp_cmd[cyc].we);
        chk("busy", BUSY, e_busy);
        chk("rsp0_vld", RSP0_VALID, e_r0);
        chk("rsp1_vld", RSP1_VALID, e_r1);
        if (e_men) begin
          chk("sram_addr", SRAM_ADDR, exp_cmd[cyc].addr);
          if (exp_cmd[cyc].we) begin
            chk("sram_din", SRAM_DIN, exp_cmd[cyc].din);
            chk("sram_bm", SRAM_BM, exp_cmd[cyc].bm);
          end
        end
        if (e_r0) chk("rsp0_rdata", RSP0_RDATA, exp_rsp_dat[cyc]);
        if (e_r1) chk("rsp1_rdata", RSP1_RDATA, exp_rsp_dat[cyc]);

        // DUT observations for the directed checks and requester handshakes.
        if (REQ0_VALID && REQ0_READY) begin acc_seen[0] = 1; acc_cyc0 = cyc; gnt_log.push_back(0); end
        if (REQ1_VALID && REQ1_READY) begin acc_seen[1] = 1; gnt_log.push_back(1); end
        if (REQ0_READY || REQ1_READY) ready_cnt++;
        if (SRAM_MEN) men_cnt++;
        if (RSP0_VALID) begin rsp0_cnt++; last_rsp0_cyc = cyc; last_rsp0_dat = RSP0_RDATA; end
        if (RSP1_VALID) rsp1_cnt++;

        // Advance the model across the coming edge.
        if (eg0 || eg1) begin
          gid = eg1 ? 1 : 0;
          c = eg1 ? '{REQ1_WE, REQ1_ADDR, REQ1_WDATA, REQ1_BM}
                  : '{REQ0_WE, REQ0_ADDR, REQ0_WDATA, REQ0_BM};
          exp_cmd[cyc + 1] = c;
          busy_mark[cyc + 1] = 1;
          if (c.we) begin
            ref_mem[c.addr] = (ref_mem[c.addr] & ~c.bm) | (c.din & c.bm);
          end else begin
            exp_rsp_id[cyc + LAT]  = gid;
            exp_rsp_dat[cyc + LAT] = ref_mem[c.addr];
            for (int k = 1; k <= LAT; k++) busy_mark[cyc + k] = 1;
          end
          last_g = gid;
        end
        case (mode)
          0: if (CONFIGURED) mode = 1;
          1: if (!CONFIGURED) mode = 2;
          default: if (!e_busy) mode = 0;
        endcase
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic set_req(input int id, input bit v, input bit we, input logic [9:0] a,
                         input logic [31:0] d, input logic [31:0] m);
    if (id == 0) begin REQ0_VALID = v; REQ0_WE = we; REQ0_ADDR = a; REQ0_WDATA = d; REQ0_BM = m; end
    else         begin REQ1_VALID = v; REQ1_WE = we; REQ1_ADDR = a; REQ1_WDATA = d; REQ1_BM = m; end
  endtask

  task automatic issue(input int id, input bit we, input logic [9:0] a,
                       input logic [31:0] d, input logic [31:0] m);
    int k;
    acc_seen[id] = 0;
    set_req(id, 1, we, a, d, m);
    k = 0;
    while (!acc_seen[id] && k < 20) begin step(); k++; end
    chk("issue_accept", {31'd0, acc_seen[id]}, 1);
    set_req(id, 0, we, a, d, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int r0, r1, rc, m0, a;
    repeat (3) step();
    RST_N = 1'b1;

    // 1: unconfigured, request held -> no grant, macro idle for 10 cycles.
    rc = ready_cnt; m0 = men_cnt;
    set_req(0, 1, 0, 10'h001, 0, 0);
    repeat (10) step();
    chk("t1_ready_cnt", ready_cnt - rc, 0);
    chk("t1_men_cnt", men_cnt - m0, 0);
    set_req(0, 0, 0, 10'h001, 0, 0);
    CONFIGURED = 1'b1;
    repeat (2) step();

    // 2: single requester write then read of the top address.
    r1 = rsp1_cnt;
    issue(0, 1, 10'h3FF, 32'hDEADBEEF, 32'hFFFFFFFF);
    issue(0, 0, 10'h3FF, 0, 0);
    a = acc_cyc0;
    repeat (LAT + 1) step();
    chk("t2_rsp_latency", last_rsp0_cyc - a, LAT);
    chk("t2_rsp_data", last_rsp0_dat, 32'hDEADBEEF);
    chk("t2_rsp1_quiet", rsp1_cnt - r1, 0);

    // 4: masked write merges with existing contents.
    issue(1, 1, 10'h100, 32'hAAAAAAAA, 32'hFFFFFFFF);
    issue(0, 1, 10'h100, 32'h12345678, 32'h0000FFFF);
    issue(0, 0, 10'h100, 0, 0);
    repeat (LAT + 1) step();
    chk("t4_merge", last_rsp0_dat, 32'hAAAA5678);

    // 3: fresh reset, then both requesters valid for 8 cycles.
    RST_N = 1'b0;
    repeat (2) step();
    RST_N = 1'b1;
    repeat (2) step();
    gnt_log.delete();
    m0 = men_cnt;
    set_req(0, 1, 0, 10'h010, 0, 0);
    set_req(1, 1, 0, 10'h020, 0, 0);
    repeat (8) step();
    set_req(0, 0, 0, 10'h010, 0, 0);
    set_req(1, 0, 0, 10'h020, 0, 0);
    repeat (LAT + 1) step();
    chk("t3_grants", gnt_log.size(), 8);
    for (int k = 0; k < gnt_log.size(); k++) chk("t3_order", gnt_log[k], k % 2);
    chk("t3_men_cycles", men_cnt - m0, 8);

    // 5: CONFIGURED drops with two reads in flight; a held request must wait.
    r0 = rsp0_cnt; r1 = rsp1_cnt;
    acc_seen[0] = 0; acc_seen[1] = 0;
    set_req(0, 1, 0, 10'h3FF, 0, 0);
    set_req(1, 1, 0, 10'h100, 0, 0);
    step();
    if (acc_seen[0]) REQ0_VALID = 1'b0;
    if (acc_seen[1]) REQ1_VALID = 1'b0;
    step();
    CONFIGURED = 1'b0;
    REQ1_VALID = 1'b0;
    chk("t5_both_taken", {30'd0, acc_seen[1], acc_seen[0]}, 3);
    rc = ready_cnt;
    acc_seen[0] = 0;
    set_req(0, 1, 0, 10'h3FF, 0, 0);
    repeat (6) step();
    chk("t5_rsp0", rsp0_cnt - r0, 1);
    chk("t5_rsp1", rsp1_cnt - r1, 1);
    chk("t5_no_ready", ready_cnt - rc, 0);
    chk("t5_busy", BUSY, 0);
    CONFIGURED = 1'b1;
    step();
    chk("t5_unconf_cycle", acc_seen[0], 0);
    step();
    chk("t5_run_accept", acc_seen[0], 1);
    REQ0_VALID = 1'b0;
    repeat (LAT + 1) step();

    // 6: read then asynchronous reset before data returns -> no pulse.
    issue(0, 0, 10'h3FF, 0, 0);
    r0 = rsp0_cnt;
    RST_N = 1'b0;
    repeat (2) step();
    RST_N = 1'b1;
    repeat (LAT + 3) step();
    chk("t6_no_rsp", rsp0_cnt - r0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
